// File: rtl/xbar_cfg_pkg.sv
// xbar_cfg_pkg: shared sizes, selector type and loader FSM states for the crossbar config loader.
package xbar_cfg_pkg;
    localparam int NUM_IN  = 27;
    localparam int NUM_OUT = 36;
    localparam int SEL_W   = 5;
    localparam int IDX_W   = 6;
    localparam int CFG_W   = NUM_OUT * SEL_W;
    typedef logic [SEL_W-1:0] sel_t;
    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
endpackage

// File: rtl/xbar_cfg_loader.sv
// xbar_cfg_loader: word-serial selector loader with atomic shadow-to-active commit.
// Optional readback of the active register when XBAR_CFG_READBACK_EN is defined.
module xbar_cfg_loader
    import xbar_cfg_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             io_start,
    input  logic             io_cfg_valid,
    output logic             io_cfg_ready,
    input  sel_t             io_cfg_sel,
    output logic [CFG_W-1:0] io_mux_configs,
`ifdef XBAR_CFG_READBACK_EN
    input  logic [IDX_W-1:0] io_rd_idx,
    output sel_t             io_rd_sel,
`endif
    output logic             io_busy,
    output logic             io_done,
    output logic             io_err
);
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CFG_W-1:0]   shadow_q, shadow_d;
    logic [CFG_W-1:0]   active_q, active_d;
    logic               err_q, err_d;
    logic               done_q, done_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        active_d = active_q;
        err_d    = err_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (io_start) begin
                state_d = LOAD;
                idx_d   = '0;
                err_d   = 1'b0;
            end
            // a restart wins over a beat in the same cycle; the shadow is left as is
            LOAD: if (io_start) begin
                idx_d = '0;
                err_d = 1'b0;
            end else if (io_cfg_valid) begin
                shadow_d[int'(idx_q)*SEL_W +: SEL_W] = io_cfg_sel;
                if (io_cfg_sel >= SEL_W'(NUM_IN))
                    err_d = 1'b1;
                if (idx_q == IDX_W'(NUM_OUT - 1)) begin
                    idx_d   = '0;
                    state_d = COMMIT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            COMMIT: begin
                active_d = err_q ? active_q : shadow_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign io_cfg_ready   = state_q == LOAD;
    assign io_busy        = state_q != IDLE;
    assign io_done        = done_q;
    assign io_err         = err_q;
    assign io_mux_configs = active_q;

`ifdef XBAR_CFG_READBACK_EN
    assign io_rd_sel = (io_rd_idx < IDX_W'(NUM_OUT)) ? active_q[int'(io_rd_idx)*SEL_W +: SEL_W] : '0;
`endif
endmodule

// File: tb/tb_xbar_cfg_loader.sv
// tb_xbar_cfg_loader: randomized frames checked against an array model of the active selectors.
// Readback checks are included when XBAR_CFG_READBACK_EN is defined.
module tb_xbar_cfg_loader;
    import xbar_cfg_pkg::*;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             io_start = 1'b0;
    logic             io_cfg_valid = 1'b0;
    logic             io_cfg_ready;
    logic [SEL_W-1:0] io_cfg_sel = '0;
    logic [CFG_W-1:0] io_mux_configs;
    logic             io_busy, io_done, io_err;
`ifdef XBAR_CFG_READBACK_EN
    logic [IDX_W-1:0] io_rd_idx = '0;
    logic [SEL_W-1:0] io_rd_sel;
`endif

    int checks = 0;
    int failures = 0;
    int model_act [NUM_OUT];

    xbar_cfg_loader dut (
        .clk(clk),
        .reset(reset),
        .io_start(io_start),
        .io_cfg_valid(io_cfg_valid),
        .io_cfg_ready(io_cfg_ready),
        .io_cfg_sel(io_cfg_sel),
        .io_mux_configs(io_mux_configs),
`ifdef XBAR_CFG_READBACK_EN
        .io_rd_idx(io_rd_idx),
        .io_rd_sel(io_rd_sel),
`endif
        .io_busy(io_busy),
        .io_done(io_done),
        .io_err(io_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [CFG_W-1:0] got, input logic [CFG_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [CFG_W-1:0] model_vec();
        logic [CFG_W-1:0] v = '0;
        for (int k = 0; k < NUM_OUT; k++)
            v[k*SEL_W +: SEL_W] = SEL_W'(model_act[k]);
        return v;
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "_cfg"}, io_mux_configs, '0);
        check({tag, "_ready"}, CFG_W'(io_cfg_ready), '0);
        check({tag, "_busy"}, CFG_W'(io_busy), '0);
        check({tag, "_done"}, CFG_W'(io_done), '0);
        check({tag, "_err"}, CFG_W'(io_err), '0);
    endtask

    // called at a negedge; returns at the negedge after the beat's accepting edge
    task automatic drive_beat(input int s, input bit gapped);
        if (gapped) begin
            io_cfg_valid = 1'b0;
            repeat (2) @(negedge clk);
            check("gap_ready", CFG_W'(io_cfg_ready), 1);
        end
        io_cfg_valid = 1'b1;
        io_cfg_sel = SEL_W'(s);
        @(negedge clk);
        io_cfg_valid = 1'b0;
    endtask

    task automatic start_frame();
        io_start = 1'b1;
        io_cfg_valid = 1'b1;
        io_cfg_sel = SEL_W'($urandom_range(0, 31));
        @(negedge clk);
        io_start = 1'b0;
        io_cfg_valid = 1'b0;
        check("start_ready", CFG_W'(io_cfg_ready), 1);
        check("start_busy", CFG_W'(io_busy), 1);
        check("start_err_clear", CFG_W'(io_err), 0);
    endtask

    task automatic run_frame(input bit det, input int bad_pos, input int restart_at, input bit gapped);
        int sels [NUM_OUT];
        bit bad = 1'b0;
        for (int k = 0; k < NUM_OUT; k++)
            sels[k] = det ? k % NUM_IN : int'($urandom_range(0, NUM_IN - 1));
        if (bad_pos >= 0)
            sels[bad_pos] = det ? 31 : int'($urandom_range(NUM_IN, 31));
        start_frame();
        if (restart_at >= 0) begin
            for (int i = 0; i < restart_at; i++)
                drive_beat(i == 3 ? 30 : int'($urandom_range(0, 31)), 1'b0);
            io_start = 1'b1;
            io_cfg_valid = 1'b1;
            io_cfg_sel = 5'd31;
            @(negedge clk);
            io_start = 1'b0;
            io_cfg_valid = 1'b0;
            check("restart_err_clear", CFG_W'(io_err), 0);
            check("restart_busy", CFG_W'(io_busy), 1);
        end
        for (int k = 0; k < NUM_OUT; k++) begin
            check("no_early_done", CFG_W'(io_done), 0);
`ifdef XBAR_CFG_READBACK_EN
            if (k == 18) begin
                io_rd_idx = IDX_W'($urandom_range(0, NUM_OUT - 1));
                #1 check("rd_mid_frame", CFG_W'(io_rd_sel), CFG_W'(model_act[io_rd_idx]));
            end
`endif
            drive_beat(sels[k], gapped);
        end
        check("commit_ready", CFG_W'(io_cfg_ready), 0);
        check("commit_busy", CFG_W'(io_busy), 1);
        check("commit_done_low", CFG_W'(io_done), 0);
        check("commit_cfg_old", io_mux_configs, model_vec());
        io_start = 1'b1;
        io_cfg_valid = 1'b1;
        io_cfg_sel = '0;
        for (int k = 0; k < NUM_OUT; k++)
            bad |= sels[k] >= NUM_IN;
        if (!bad)
            for (int k = 0; k < NUM_OUT; k++)
                model_act[k] = sels[k];
        @(negedge clk);
        io_start = 1'b0;
        check("done_pulse", CFG_W'(io_done), 1);
        check("cfg_after_commit", io_mux_configs, model_vec());
        check("err_flag", CFG_W'(io_err), CFG_W'(bad));
        check("idle_busy", CFG_W'(io_busy), 0);
        check("idle_ready", CFG_W'(io_cfg_ready), 0);
`ifdef XBAR_CFG_READBACK_EN
        io_rd_idx = 6'd35;
        #1 check("rd_idx35", CFG_W'(io_rd_sel), CFG_W'(model_act[35]));
        io_rd_idx = 6'd40;
        #1 check("rd_idx40", CFG_W'(io_rd_sel), 0);
`endif
        @(negedge clk);
        io_cfg_valid = 1'b0;
        check("done_low", CFG_W'(io_done), 0);
        check("start_in_commit_ignored", CFG_W'(io_cfg_ready), 0);
        check("err_held", CFG_W'(io_err), CFG_W'(bad));
        check("cfg_stable", io_mux_configs, model_vec());
    endtask

    initial begin
        for (int k = 0; k < NUM_OUT; k++)
            model_act[k] = 0;
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        check_idle_zero("post_reset");

        run_frame(1'b1, -1, -1, 1'b0);
        for (int f = 0; f < 3; f++)
            run_frame(1'b0, -1, -1, f == 1);
        run_frame(1'b1, 10, -1, 1'b0);
        run_frame(1'b0, -1, -1, 1'b0);
        run_frame(1'b0, int'($urandom_range(0, NUM_OUT - 1)), -1, 1'b1);
        run_frame(1'b0, -1, 20, 1'b0);

        start_frame();
        for (int i = 0; i < 17; i++)
            drive_beat(i == 5 ? 29 : int'($urandom_range(0, NUM_IN - 1)), 1'b0);
        check("pre_reset_err", CFG_W'(io_err), 1);
        check("pre_reset_busy", CFG_W'(io_busy), 1);
        reset = 1'b0;
        for (int k = 0; k < NUM_OUT; k++)
            model_act[k] = 0;
        #1 check_idle_zero("async_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_frame(1'b0, -1, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
